// File: rtl/adc_req_arbiter.sv
// Round-robin arbiter sharing one ADC register/data driver between requesters A (MCU) and B (auto-scan).
// Optional per-transaction watchdog is enabled by defining ADC_ARB_TIMEOUT_EN.
module adc_req_arbiter #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1000000
) (
  input  logic        CLK_100MHz,
  input  logic        nRESET,
  input  logic        A_REQ,
  input  logic        B_REQ,
  input  logic [1:0]  A_OP,
  input  logic [1:0]  B_OP,
  input  logic [4:0]  A_ADDR,
  input  logic [4:0]  B_ADDR,
  input  logic [7:0]  A_WDATA,
  input  logic [7:0]  B_WDATA,
  output logic        A_GNT,
  output logic        B_GNT,
  output logic        A_DONE,
  output logic        B_DONE,
  output logic        A_ERR,
  output logic        B_ERR,
  output logic [31:0] A_RDATA,
  output logic [31:0] B_RDATA,
  input  logic        DRV_READY,
  input  logic        DRV_DONE,
  input  logic [7:0]  DRV_REG_BUFFER,
  input  logic [31:0] DRV_DATA_BUFFER,
  output logic        DRV_WRITE_REG_EN,
  output logic        DRV_READ_REG_EN,
  output logic        DRV_READ_DATA_EN,
  output logic [4:0]  DRV_ADDRESS,
  output logic [7:0]  DRV_WDATA,
  output logic        BUSY,
  output logic        OWNER,
  output logic        TIMEOUT_FLAG,
  input  logic        TIMEOUT_CLR
);

  localparam logic [1:0] OP_WRITE_REG = 2'b00;
  localparam logic [1:0] OP_READ_REG  = 2'b01;
  localparam logic [1:0] OP_READ_DATA = 2'b10;
  localparam logic [1:0] OP_INVALID   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t      state;
  logic        last_b;
  logic [1:0]  op_q;
  logic        pick_b;
  logic [1:0]  sel_op;
  logic [4:0]  sel_addr;
  logic [7:0]  sel_wdata;
  logic [31:0] drv_result;

  // B wins only when A is idle or A was the one served most recently.
  always_comb begin
    pick_b    = B_REQ && (!A_REQ || !last_b);
    sel_op    = pick_b ? B_OP    : A_OP;
    sel_addr  = pick_b ? B_ADDR  : A_ADDR;
    sel_wdata = pick_b ? B_WDATA : A_WDATA;
    unique case (op_q)
      OP_READ_REG:  drv_result = {24'd0, DRV_REG_BUFFER};
      OP_READ_DATA: drv_result = DRV_DATA_BUFFER;
      default:      drv_result = 32'd0;
    endcase
  end

`ifdef ADC_ARB_TIMEOUT_EN
  logic [31:0] busy_cnt;
  logic        timeout_hit;

  always_comb begin
    timeout_hit = (state == ST_BUSY) && !DRV_DONE && ((busy_cnt + 32'd1) >= TIMEOUT_CYCLES);
  end
`else
  logic unused_cfg;
  assign unused_cfg   = TIMEOUT_CLR ^ (TIMEOUT_CYCLES == 32'd0);
  assign TIMEOUT_FLAG = 1'b0;
`endif

  always_ff @(posedge CLK_100MHz or negedge nRESET) begin
    if (!nRESET) begin
      state            <= ST_IDLE;
      last_b           <= 1'b1;
      op_q             <= OP_WRITE_REG;
      A_GNT            <= 1'b0;
      B_GNT            <= 1'b0;
      A_DONE           <= 1'b0;
      B_DONE           <= 1'b0;
      A_ERR            <= 1'b0;
      B_ERR            <= 1'b0;
      A_RDATA          <= 32'd0;
      B_RDATA          <= 32'd0;
      DRV_WRITE_REG_EN <= 1'b0;
      DRV_READ_REG_EN  <= 1'b0;
      DRV_READ_DATA_EN <= 1'b0;
      DRV_ADDRESS      <= 5'd0;
      DRV_WDATA        <= 8'd0;
      BUSY             <= 1'b0;
      OWNER            <= 1'b0;
`ifdef ADC_ARB_TIMEOUT_EN
      busy_cnt         <= 32'd0;
      TIMEOUT_FLAG     <= 1'b0;
`endif
    end else begin
      A_DONE <= 1'b0;
      B_DONE <= 1'b0;
      A_ERR  <= 1'b0;
      B_ERR  <= 1'b0;
`ifdef ADC_ARB_TIMEOUT_EN
      // A timeout set later in this block overrides a simultaneous clear.
      if (TIMEOUT_CLR) TIMEOUT_FLAG <= 1'b0;
`endif
      unique case (state)
        ST_IDLE: begin
          if (DRV_READY && (A_REQ || B_REQ)) begin
            last_b      <= pick_b;
            OWNER       <= pick_b;
            op_q        <= sel_op;
            DRV_ADDRESS <= sel_addr;
            DRV_WDATA   <= sel_wdata;
            if (sel_op == OP_INVALID) begin
              state <= ST_RELEASE;
              if (pick_b) begin
                B_DONE  <= 1'b1;
                B_ERR   <= 1'b1;
                B_RDATA <= 32'd0;
              end else begin
                A_DONE  <= 1'b1;
                A_ERR   <= 1'b1;
                A_RDATA <= 32'd0;
              end
            end else begin
              state            <= ST_BUSY;
              BUSY             <= 1'b1;
              A_GNT            <= !pick_b;
              B_GNT            <= pick_b;
              DRV_WRITE_REG_EN <= (sel_op == OP_WRITE_REG);
              DRV_READ_REG_EN  <= (sel_op == OP_READ_REG);
              DRV_READ_DATA_EN <= (sel_op == OP_READ_DATA);
`ifdef ADC_ARB_TIMEOUT_EN
              busy_cnt         <= 32'd0;
`endif
            end
          end
        end
        ST_BUSY: begin
          if (DRV_DONE) begin
            state            <= ST_RELEASE;
            BUSY             <= 1'b0;
            A_GNT            <= 1'b0;
            B_GNT            <= 1'b0;
            DRV_WRITE_REG_EN <= 1'b0;
            DRV_READ_REG_EN  <= 1'b0;
            DRV_READ_DATA_EN <= 1'b0;
            if (OWNER) begin
              B_DONE  <= 1'b1;
              B_RDATA <= drv_result;
            end else begin
              A_DONE  <= 1'b1;
              A_RDATA <= drv_result;
            end
          end
`ifdef ADC_ARB_TIMEOUT_EN
          else if (timeout_hit) begin
            state            <= ST_RELEASE;
            BUSY             <= 1'b0;
            A_GNT            <= 1'b0;
            B_GNT            <= 1'b0;
            DRV_WRITE_REG_EN <= 1'b0;
            DRV_READ_REG_EN  <= 1'b0;
            DRV_READ_DATA_EN <= 1'b0;
            TIMEOUT_FLAG     <= 1'b1;
            if (OWNER) begin
              B_DONE <= 1'b1;
              B_ERR  <= 1'b1;
            end else begin
              A_DONE <= 1'b1;
              A_ERR  <= 1'b1;
            end
          end else begin
            busy_cnt <= busy_cnt + 32'd1;
          end
`endif
        end
        ST_RELEASE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_req_arbiter.sv
// Directed self-checking bench for adc_req_arbiter; inputs change and outputs are sampled on the falling edge.
// Covers the watchdog path when ADC_ARB_TIMEOUT_EN is defined, otherwise checks that BUSY waits indefinitely.
module tb_adc_req_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_req, b_req;
  logic [1:0]  a_op, b_op;
  logic [4:0]  a_addr, b_addr;
  logic [7:0]  a_wdata, b_wdata;
  logic        a_gnt, b_gnt, a_done, b_done, a_err, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic        drv_ready, drv_done;
  logic [7:0]  drv_reg_buffer;
  logic [31:0] drv_data_buffer;
  logic        drv_write_reg_en, drv_read_reg_en, drv_read_data_en;
  logic [4:0]  drv_address;
  logic [7:0]  drv_wdata;
  logic        busy, owner, timeout_flag, timeout_clr;

  int num_checks = 0;
  int num_fails  = 0;
  int en_cycles;
  logic exp_owner;

  always #5 clk = ~clk;

  adc_req_arbiter #(.TIMEOUT_CYCLES(32'd20)) dut (
    .CLK_100MHz(clk), .nRESET(rst_n),
    .A_REQ(a_req), .B_REQ(b_req), .A_OP(a_op), .B_OP(b_op),
    .A_ADDR(a_addr), .B_ADDR(b_addr), .A_WDATA(a_wdata), .B_WDATA(b_wdata),
    .A_GNT(a_gnt), .B_GNT(b_gnt), .A_DONE(a_done), .B_DONE(b_done),
    .A_ERR(a_err), .B_ERR(b_err), .A_RDATA(a_rdata), .B_RDATA(b_rdata),
    .DRV_READY(drv_ready), .DRV_DONE(drv_done),
    .DRV_REG_BUFFER(drv_reg_buffer), .DRV_DATA_BUFFER(drv_data_buffer),
    .DRV_WRITE_REG_EN(drv_write_reg_en), .DRV_READ_REG_EN(drv_read_reg_en),
    .DRV_READ_DATA_EN(drv_read_data_en), .DRV_ADDRESS(drv_address), .DRV_WDATA(drv_wdata),
    .BUSY(busy), .OWNER(owner), .TIMEOUT_FLAG(timeout_flag), .TIMEOUT_CLR(timeout_clr)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic is_b, input logic req, input logic [1:0] op,
                               input logic [4:0] addr, input logic [7:0] wdata);
    if (is_b) begin
      b_req = req; b_op = op; b_addr = addr; b_wdata = wdata;
    end else begin
      a_req = req; a_op = op; a_addr = addr; a_wdata = wdata;
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One-cycle DRV_DONE; on return the arbiter's completion outputs are visible.
  task automatic pulseDrvDone();
    drv_done = 1'b1;
    tick();
    drv_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; drv_ready = 1'b1; drv_done = 1'b0; timeout_clr = 1'b0;
    drv_reg_buffer = 8'h00; drv_data_buffer = 32'd0;
    applyStimulus(1'b0, 1'b0, 2'b00, 5'h00, 8'h00);
    applyStimulus(1'b1, 1'b0, 2'b00, 5'h00, 8'h00);
    tick(); tick();
    checkOutput("reset_ctrl", 32'({a_gnt, b_gnt, a_done, b_done, a_err, b_err, busy, owner, timeout_flag}), 32'd0);
    checkOutput("reset_rdata", a_rdata | b_rdata, 32'd0);
    checkOutput("reset_drv", 32'({drv_write_reg_en, drv_read_reg_en, drv_read_data_en, drv_address, drv_wdata}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Register write from A, driver finishes after 10 enable cycles.
    applyStimulus(1'b0, 1'b1, 2'b00, 5'h02, 8'h5C);
    en_cycles = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (drv_write_reg_en) en_cycles++;
      if (k == 1) begin
        checkOutput("wr_gnt", 32'({a_gnt, b_gnt, busy, owner}), 32'b1010);
        checkOutput("wr_en", 32'({drv_write_reg_en, drv_read_reg_en, drv_read_data_en}), 32'b100);
        checkOutput("wr_addr", 32'(drv_address), 32'h02);
        checkOutput("wr_wdata", 32'(drv_wdata), 32'h5C);
      end
      if (k == 10) begin
        checkOutput("wr_hold", 32'({drv_address, drv_wdata, a_gnt}), 32'({5'h02, 8'h5C, 1'b1}));
        drv_done = 1'b1;
      end
    end
    tick();
    drv_done = 1'b0;
    checkOutput("wr_en_cycles", 32'(en_cycles), 32'd10);
    checkOutput("wr_done", 32'({a_done, a_err, b_done, a_gnt, busy, drv_write_reg_en}), 32'b100000);
    checkOutput("wr_rdata", a_rdata, 32'd0);
    applyStimulus(1'b0, 1'b0, 2'b00, 5'h00, 8'h00);
    tick();
    checkOutput("wr_done_pulse", 32'({a_done, b_done}), 32'd0);

    // Stray DRV_DONE while idle must not complete anything.
    pulseDrvDone();
    checkOutput("idle_drv_done", 32'({a_done, b_done, busy, a_gnt, b_gnt}), 32'd0);
    tick();

    // Register read from A returns the zero-extended register buffer.
    drv_reg_buffer = 8'hA7;
    applyStimulus(1'b0, 1'b1, 2'b01, 5'h0A, 8'h00);
    tick();
    checkOutput("rdreg_en", 32'({drv_write_reg_en, drv_read_reg_en, drv_read_data_en}), 32'b010);
    pulseDrvDone();
    checkOutput("rdreg_done", 32'({a_done, a_err}), 32'b10);
    checkOutput("rdreg_rdata", a_rdata, 32'h000000A7);
    applyStimulus(1'b0, 1'b0, 2'b00, 5'h00, 8'h00);
    tick();

    // B data read; B drops REQ and A's inputs wiggle while B owns the driver.
    applyStimulus(1'b1, 1'b1, 2'b10, 5'h07, 8'h33);
    tick();
    checkOutput("b_gnt", 32'({a_gnt, b_gnt, owner, busy}), 32'b0111);
    checkOutput("b_en", 32'({drv_write_reg_en, drv_read_reg_en, drv_read_data_en}), 32'b001);
    applyStimulus(1'b1, 1'b0, 2'b00, 5'h00, 8'h00);
    applyStimulus(1'b0, 1'b0, 2'b00, 5'h1F, 8'hFF);
    drv_data_buffer = 32'h00123456;
    tick();
    checkOutput("b_isolation", 32'({drv_address, drv_wdata, busy}), 32'({5'h07, 8'h33, 1'b1}));
    pulseDrvDone();
    checkOutput("b_done", 32'({b_done, b_err, a_done}), 32'b100);
    checkOutput("b_rdata", b_rdata, 32'h00123456);
    checkOutput("b_a_rdata_kept", a_rdata, 32'h000000A7);
    tick();

    // Invalid op from A completes immediately with an error and no driver enable.
    applyStimulus(1'b0, 1'b1, 2'b11, 5'h03, 8'h00);
    tick();
    checkOutput("inv_done", 32'({a_done, a_err, b_done, busy}), 32'b1100);
    checkOutput("inv_en", 32'({drv_write_reg_en, drv_read_reg_en, drv_read_data_en}), 32'd0);
    checkOutput("inv_rdata", a_rdata, 32'd0);
    applyStimulus(1'b0, 1'b0, 2'b00, 5'h00, 8'h00);
    tick();
    checkOutput("inv_pulse", 32'({a_done, a_err}), 32'd0);

    // Asynchronous reset in the middle of a transaction.
    applyStimulus(1'b0, 1'b1, 2'b00, 5'h04, 8'h11);
    tick();
    checkOutput("rst_pre_busy", 32'({busy, a_gnt}), 32'b11);
    tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_async_ctrl", 32'({a_gnt, b_gnt, a_done, b_done, a_err, b_err, busy, owner, timeout_flag}), 32'd0);
    checkOutput("rst_async_drv", 32'({drv_write_reg_en, drv_read_reg_en, drv_read_data_en, drv_address, drv_wdata}), 32'd0);
    checkOutput("rst_async_rdata", a_rdata | b_rdata, 32'd0);
    applyStimulus(1'b0, 1'b0, 2'b00, 5'h00, 8'h00);
    tick();
    rst_n = 1'b1;
    tick(); tick();
    checkOutput("rst_no_resume", 32'({a_done, busy, a_gnt}), 32'd0);

    // Both requesting and held: A first after reset, then alternate.
    applyStimulus(1'b0, 1'b1, 2'b01, 5'h05, 8'h00);
    applyStimulus(1'b1, 1'b1, 2'b01, 5'h06, 8'h00);
    for (int t = 0; t < 4; t++) begin
      tick();
      exp_owner = (t % 2) == 1;
      checkOutput($sformatf("rr_owner_%0d", t), 32'(owner), 32'(exp_owner));
      checkOutput($sformatf("rr_gnt_%0d", t), 32'({a_gnt, b_gnt}), exp_owner ? 32'b01 : 32'b10);
      drv_reg_buffer = 8'h10 + 8'(t);
      pulseDrvDone();
      checkOutput($sformatf("rr_done_%0d", t), 32'({a_done, b_done}), exp_owner ? 32'b01 : 32'b10);
      checkOutput($sformatf("rr_rdata_%0d", t), exp_owner ? b_rdata : a_rdata, 32'h10 + 32'(t));
      if (t == 3) begin
        applyStimulus(1'b0, 1'b0, 2'b00, 5'h00, 8'h00);
        applyStimulus(1'b1, 1'b0, 2'b00, 5'h00, 8'h00);
      end
      tick();
    end

`ifdef ADC_ARB_TIMEOUT_EN
    // Driver never answers: watchdog ends the transaction after 20 busy cycles.
    applyStimulus(1'b0, 1'b1, 2'b00, 5'h08, 8'h22);
    en_cycles = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (drv_write_reg_en) en_cycles++;
    end
    tick();
    checkOutput("to_en_cycles", 32'(en_cycles), 32'd20);
    checkOutput("to_done", 32'({a_done, a_err, a_gnt, drv_write_reg_en, timeout_flag}), 32'b11001);
    checkOutput("to_rdata_kept", a_rdata, 32'h00000012);
    applyStimulus(1'b0, 1'b0, 2'b00, 5'h00, 8'h00);
    tick(); tick();
    checkOutput("to_flag_sticky", 32'({timeout_flag, a_done}), 32'b10);
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    checkOutput("to_flag_clr", 32'(timeout_flag), 32'd0);
`else
    // Without the watchdog the arbiter waits for DRV_DONE however long it takes.
    applyStimulus(1'b0, 1'b1, 2'b00, 5'h08, 8'h22);
    en_cycles = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (drv_write_reg_en) en_cycles++;
      timeout_clr = (k == 5);
    end
    timeout_clr = 1'b0;
    checkOutput("nto_en_cycles", 32'(en_cycles), 32'd40);
    checkOutput("nto_flag", 32'({timeout_flag, busy, a_done}), 32'b010);
    pulseDrvDone();
    checkOutput("nto_done", 32'({a_done, a_err, busy}), 32'b100);
    checkOutput("nto_rdata", a_rdata, 32'd0);
    applyStimulus(1'b0, 1'b0, 2'b00, 5'h00, 8'h00);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule

// File: doc/adc_req_arbiter.md
ADC_REQ_ARBITER -- requirements
Module: adc_req_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 32'd1000000, watchdog limit in clock cycles per transaction.
REQ-002 SHALL have CLK_100MHz  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have nRESET  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have A_REQ/B_REQ  input  1 each  transaction request from requester A (MCU) / B (auto-scan), level.
REQ-005 SHALL have A_OP/B_OP  input  2 each  00 write register, 01 read register, 10 read conversion data, 11 invalid.
REQ-006 SHALL have A_ADDR/B_ADDR  input  5 each, and A_WDATA/B_WDATA  input  8 each  register address / write data.
REQ-007 SHALL have A_GNT/B_GNT  output  1 each  requester owns the driver.
REQ-008 SHALL have A_DONE/B_DONE  output  1 each  one-cycle completion pulse; A_ERR/B_ERR  output  1 each  error qualifier, valid with DONE.
REQ-009 SHALL have A_RDATA/B_RDATA  output  32 each  result, valid from DONE until that requester's next DONE.
REQ-010 SHALL have DRV_READY  input  1, DRV_DONE  input  1, DRV_REG_BUFFER  input  8, DRV_DATA_BUFFER  input  32  driver status/results.
REQ-011 SHALL have DRV_WRITE_REG_EN, DRV_READ_REG_EN, DRV_READ_DATA_EN  output  1 each; DRV_ADDRESS  output  5; DRV_WDATA  output  8  driver commands.
REQ-012 SHALL have BUSY  output  1, OWNER  output  1 (0=A, 1=B), TIMEOUT_FLAG  output  1, TIMEOUT_CLR  input  1.

Function
REQ-013 SHALL implement states IDLE, BUSY, RELEASE.
REQ-014 IDLE: when DRV_READY=1 and any REQ=1, SHALL grant per REQ-015, latch that requester's OP/ADDR/WDATA, go to BUSY next cycle; otherwise stay.
REQ-015 Arbitration SHALL be round-robin: single requester wins; both requesting -> requester not served last wins; after reset A has priority.
REQ-016 Grant at IDLE cycle N SHALL give, at N+1: GNT=1, BUSY=1, OWNER set, exactly one EN high per latched OP, DRV_ADDRESS/DRV_WDATA from latched values.
REQ-017 EN, GNT, address and data SHALL stay constant in BUSY until DRV_DONE=1 is sampled.
REQ-018 DRV_DONE sampled at cycle M SHALL give at M+1: EN=0, GNT=0, owner DONE=1 for one cycle, ERR=0, RDATA updated; state RELEASE.
REQ-019 RDATA SHALL be {24'd0, DRV_REG_BUFFER} for OP 01, DRV_DATA_BUFFER for OP 10, 32'd0 for OP 00.
REQ-020 RELEASE SHALL last one cycle, then IDLE; arbitration resumes no earlier than M+2.
REQ-021 Requester SHALL deassert REQ in the cycle after DONE; REQ still high in IDLE SHALL be a new request.
REQ-022 OP 11 at grant SHALL assert no driver EN, pulse DONE with ERR=1 and RDATA=32'd0 at N+1, then RELEASE.
REQ-023 REQ deasserted while BUSY SHALL be ignored; transaction completes and DONE still pulses.
REQ-024 Inputs from the non-owner SHALL not affect driver outputs or owner results.
REQ-025 DRV_DONE in IDLE or RELEASE SHALL be ignored.

Reset
REQ-026 nRESET low SHALL immediately force IDLE, all outputs 0 (GNT, DONE, ERR, RDATA, EN, DRV_ADDRESS, DRV_WDATA, BUSY, OWNER, TIMEOUT_FLAG), last-served = B.
REQ-027 Reset during BUSY SHALL abort without a DONE pulse; no transaction resumes after release.

Configuration
REQ-028 With ADC_ARB_TIMEOUT_EN defined, a 32-bit counter SHALL clear on BUSY entry and increment each BUSY cycle; on reaching TIMEOUT_CYCLES without DRV_DONE, next cycle EN=0, GNT=0, DONE=1, ERR=1, RDATA unchanged, TIMEOUT_FLAG=1 (sticky until TIMEOUT_CLR=1), state RELEASE; TIMEOUT_CLR and a new timeout in the same cycle SHALL leave the flag set.
REQ-029 Without ADC_ARB_TIMEOUT_EN, no counter SHALL exist, BUSY SHALL wait indefinitely for DRV_DONE, TIMEOUT_FLAG SHALL be constant 0, TIMEOUT_CLR ignored.

Verification
REQ-030 A_REQ, OP=00, ADDR=5'h02, WDATA=8'h5C; DRV_DONE 10 cycles later -> DRV_WRITE_REG_EN high 10 cycles, DRV_ADDRESS=02, DRV_WDATA=5C, A_DONE one pulse, A_RDATA=0.
REQ-031 A_REQ and B_REQ together from reset, held -> grants A, B, A, B; each DONE only to owner.
REQ-032 B OP=10, DRV_DATA_BUFFER=32'h00123456 at DRV_DONE -> B_RDATA=32'h00123456, B_ERR=0; A_RDATA unchanged.
REQ-033 A OP=11 -> A_DONE and A_ERR high at N+1, no driver EN asserted.
REQ-034 Macro defined, TIMEOUT_CYCLES=20, DRV_DONE never -> DONE+ERR after 20 BUSY cycles, TIMEOUT_FLAG=1 until TIMEOUT_CLR pulse.
REQ-035 nRESET low mid-BUSY -> all outputs 0 asynchronously, no DONE; after release A wins first simultaneous request.
